// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convolution window sequencer: FSM state
// encoding, neuron output width and flattened window indexing.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    WAIT,
    DONE
  } state_t;

  // Product width plus growth bits for summing CIN*F*F products.
  function automatic int zw_calc(input int width, input int cin, input int f);
    return 2 * width + $clog2(cin * f * f);
  endfunction

  function automatic int win_idx(input int c, input int r, input int k, input int f);
    return c * f * f + r * f + k;
  endfunction

endpackage

// File: rtl/conv_window_sched_if.sv
// Bundle of the pixel stream, neuron window/result bus and result handshake
// between the sequencer (slave) and its surroundings (master).
import conv_sched_pkg::*;

interface conv_window_sched_if #(
  parameter int WIDTH = 8,
  parameter int F     = 5,
  parameter int CIN   = 6,
  parameter int IMG_W = 14,
  parameter int IMG_H = 14,
  parameter int NOUT  = 16,
  parameter int ZW    = zw_calc(WIDTH, CIN, F)
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic                          start;
  logic                          in_valid;
  logic                          in_ready;
  logic [CIN-1:0][WIDTH-1:0]     in_pix;
  logic [CIN*F*F-1:0][WIDTH-1:0] win_x;
  logic [NOUT-1:0][ZW-1:0]       z_in;
  logic                          res_valid;
  logic                          res_ready;
  logic [NOUT-1:0][ZW-1:0]       res_z;
  logic [RW-1:0]                 res_row;
  logic [CW-1:0]                 res_col;
  logic                          done;

  modport slave (
    input  start, in_valid, in_pix, z_in, res_ready,
    output in_ready, win_x, res_valid, res_z, res_row, res_col, done
  );

  modport master (
    output start, in_valid, in_pix, z_in, res_ready,
    input  in_ready, win_x, res_valid, res_z, res_row, res_col, done
  );

endinterface

// File: rtl/conv_line_buf.sv
// Line buffer holding the previous F-1 rows of every column; each accepted
// beat reads the column stack (oldest on top) and pushes the new pixel in.
import conv_sched_pkg::*;

module conv_line_buf #(
  parameter int WIDTH = 8,
  parameter int CIN   = 6,
  parameter int F     = 5,
  parameter int IMG_W = 14,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic                                clk,
  input  logic                                wr_en_i,
  input  logic [CW-1:0]                       col_i,
  input  logic [CIN-1:0][WIDTH-1:0]           pix_i,
  output logic [F-2:0][CIN-1:0][WIDTH-1:0]    col_o
);

  typedef logic [CIN-1:0][WIDTH-1:0] pix_t;

  // Contents are deliberately not reset: rows are refilled before any window uses them.
  pix_t mem_q [IMG_W][F-1];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int r = 0; r < F - 2; r++) begin
        mem_q[col_i][r] <= mem_q[col_i][r+1];
      end
      mem_q[col_i][F-2] <= pix_i;
    end
  end

  always_comb begin
    for (int r = 0; r < F - 1; r++) begin
      col_o[r] = mem_q[col_i][r];
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// Frame sequencer: builds the FxFxCIN sliding window from a raster pixel stream
// and captures neuron outputs per position. CONV_SCHED_STATS_EN adds stall_cnt.
import conv_sched_pkg::*;

module conv_window_sched #(
  parameter int WIDTH = 8,
  parameter int F     = 5,
  parameter int CIN   = 6,
  parameter int IMG_W = 14,
  parameter int IMG_H = 14,
  parameter int NOUT  = 16,
  parameter int ZW    = zw_calc(WIDTH, CIN, F)
) (
  input  logic clk,
  input  logic rst,
  conv_window_sched_if.slave bus
`ifdef CONV_SCHED_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int NW = CIN * F * F;
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_OFF  = RW'(F - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_OFF  = CW'(F - 1);

  state_t                           state_q;
  logic [RW-1:0]                    row_q;
  logic [CW-1:0]                    col_q;
  logic                             last_q;
  logic                             in_ready_q;
  logic                             res_valid_q;
  logic                             done_q;
  logic [RW-1:0]                    res_row_q;
  logic [CW-1:0]                    res_col_q;
  logic [NOUT-1:0][ZW-1:0]          res_z_q;
  logic [WIDTH-1:0]                 win_q    [NW];
  logic [WIDTH-1:0]                 shift_in [NW];
  logic [F-2:0][CIN-1:0][WIDTH-1:0] lb_col;
  logic                             beat;
  logic                             win_full;

  assign beat     = in_ready_q && bus.in_valid;
  assign win_full = (row_q >= ROW_OFF) && (col_q >= COL_OFF);

  conv_line_buf #(
    .WIDTH (WIDTH),
    .CIN   (CIN),
    .F     (F),
    .IMG_W (IMG_W),
    .CW    (CW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en_i (beat),
    .col_i   (col_q),
    .pix_i   (bus.in_pix),
    .col_o   (lb_col)
  );

  // Each window cell takes its right neighbour; the rightmost column loads the
  // buffered column stack with the live pixel at the bottom row.
  for (genvar gi = 0; gi < CIN; gi++) begin : g_ch
    for (genvar gr = 0; gr < F; gr++) begin : g_row
      for (genvar gk = 0; gk < F; gk++) begin : g_col
        localparam int IDX = win_idx(gi, gr, gk, F);
        if (gk < F - 1) begin : g_shift
          assign shift_in[IDX] = win_q[IDX+1];
        end else if (gr < F - 1) begin : g_buf
          assign shift_in[IDX] = lb_col[gr][gi];
        end else begin : g_new
          assign shift_in[IDX] = bus.in_pix[gi];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '{default: '0};
    end else if (beat) begin
      win_q <= shift_in;
    end
  end

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      bus.win_x[i] = win_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      res_row_q   <= '0;
      res_col_q   <= '0;
      res_z_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= LOAD;
            row_q      <= '0;
            col_q      <= '0;
            in_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (beat) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            // Coordinates are taken from the beat position before the counters advance.
            if (win_full) begin
              state_q    <= EMIT;
              in_ready_q <= 1'b0;
              res_row_q  <= row_q - ROW_OFF;
              res_col_q  <= col_q - COL_OFF;
              last_q     <= (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
          end
        end
        EMIT: begin
          res_z_q     <= bus.z_in;
          res_valid_q <= 1'b1;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= LOAD;
              in_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_z     = res_z_q;
  assign bus.res_row   = res_row_q;
  assign bus.res_col   = res_col_q;
  assign bus.done      = done_q;

`ifdef CONV_SCHED_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      stall_q <= '0;
    end else if (state_q == WAIT && !bus.res_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_sched.sv
// Self-checking bench: table of frame scenarios driven through a scoreboard,
// with a behavioural neuron array feeding z_in from the window.
module tb_conv_window_sched;

  localparam int WIDTH = 8;
  localparam int F     = 5;
  localparam int CIN   = 6;
  localparam int IMG_W = 14;
  localparam int IMG_H = 14;
  localparam int NOUT  = 16;
  localparam int ZW    = WIDTH * 2 + $clog2(CIN * F * F);
  localparam int NW    = CIN * F * F;
  localparam int NTBL  = 6;

  typedef logic [NOUT-1:0][ZW-1:0] zvec_t;
  typedef logic [NW-1:0][WIDTH-1:0] win_t;
  typedef struct {
    int    row;
    int    col;
    zvec_t z;
  } exp_t;
  typedef struct {
    int seed;
    bit rand_v;
    int bp_idx;
    int bp_len;
    bit glitch;
    int abort_at;
    int exp_res;
    int exp_stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  conv_window_sched_if #(
    .WIDTH(WIDTH), .F(F), .CIN(CIN), .IMG_W(IMG_W), .IMG_H(IMG_H), .NOUT(NOUT), .ZW(ZW)
  ) bus ();

`ifdef CONV_SCHED_STATS_EN
  logic [15:0] stall_cnt;
`endif

  conv_window_sched #(
    .WIDTH(WIDTH), .F(F), .CIN(CIN), .IMG_W(IMG_W), .IMG_H(IMG_H), .NOUT(NOUT), .ZW(ZW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CONV_SCHED_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] pix(input int seed, input int r, input int c, input int ch);
    return WIDTH'((r * IMG_W + c + seed * (ch * 17 + 1)) % 128);
  endfunction

  function automatic int wgt(input int n, input int i);
    return (n * 31 + i * 7) % 255 + 1;
  endfunction

  function automatic zvec_t neuron_all(input win_t w);
    zvec_t z;
    for (int n = 0; n < NOUT; n++) begin
      int acc;
      acc = 0;
      for (int i = 0; i < NW; i++) acc += int'(w[i]) * wgt(n, i);
      z[n] = ZW'(acc);
    end
    return z;
  endfunction

  function automatic win_t win_model(input int seed, input int orow, input int ocol);
    win_t w;
    for (int c = 0; c < CIN; c++)
      for (int r = 0; r < F; r++)
        for (int k = 0; k < F; k++)
          w[c*F*F + r*F + k] = pix(seed, orow + r, ocol + k, c);
    return w;
  endfunction

  // Behavioural neuron array: combinational from the presented window.
  assign bus.z_in = neuron_all(bus.win_x);

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_z(input string name, input zvec_t act, input zvec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input win_t act, input win_t exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = NW - 1; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: element %0d got %0d, expected %0d", name, bad, act[bad], exp[bad]);
    end
  endtask

  task automatic drive_pix(input int seed, input int r, input int c);
    for (int ch = 0; ch < CIN; ch++) bus.in_pix[ch] = pix(seed, r, c, ch);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_int({tag, "_in_ready"}, int'(bus.in_ready), 0);
    check_int({tag, "_res_valid"}, int'(bus.res_valid), 0);
    check_int({tag, "_done"}, int'(bus.done), 0);
    check_int({tag, "_res_row"}, int'(bus.res_row), 0);
    check_int({tag, "_res_col"}, int'(bus.res_col), 0);
    check_z({tag, "_res_z"}, bus.res_z, '0);
    check_w({tag, "_win_x"}, bus.win_x, '0);
`ifdef CONV_SCHED_STATS_EN
    check_int({tag, "_stall_cnt"}, int'(stall_cnt), 0);
`endif
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int pr, pc, nres, bp_cnt, cyc, acc_cyc;
    bit got_done, lat_seen, rdy, vld;
    pr = 0; pc = 0; nres = 0; bp_cnt = 0; cyc = 0; acc_cyc = -100;
    got_done = 1'b0; lat_seen = 1'b0;
    sb.delete();
    @(negedge clk);
    check_int("idle_in_ready", int'(bus.in_ready), 0);
    // start with a beat offered: IDLE must not consume it
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.res_ready = 1'b1;
    drive_pix(v.seed, 0, 0);
    @(negedge clk);
    while (!got_done && cyc < 3000) begin
      bus.start = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        rdy = 1'b1;
        if (bus.res_valid) begin
          check_int("result_expected", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            if (nres == 0 && !lat_seen) begin
              lat_seen = 1'b1;
              check_int("first_latency", cyc - acc_cyc, 2);
              check_w("first_window", bus.win_x, win_model(v.seed, 0, 0));
            end
            check_int("res_row", int'(bus.res_row), sb[0].row);
            check_int("res_col", int'(bus.res_col), sb[0].col);
            check_z("res_z", bus.res_z, sb[0].z);
            check_int("in_ready_in_wait", int'(bus.in_ready), 0);
          end
          if (nres == v.bp_idx && bp_cnt < v.bp_len) begin
            rdy = 1'b0;
            bp_cnt++;
          end
          if (v.glitch && nres == 10) bus.start = 1'b1;
        end
        bus.res_ready = rdy;
        if (bus.res_valid && rdy && sb.size() != 0) begin
          void'(sb.pop_front());
          nres++;
          if (nres == v.abort_at) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check_reset_outputs("abort");
            rst = 1'b0;
            check_int("abort_result_count", nres, v.exp_res);
            $display("frame %0d: aborted by reset after %0d results", idx, nres);
            return;
          end
        end
        if (pr < IMG_H) begin
          vld = v.rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
          bus.in_valid = vld;
          drive_pix(v.seed, pr, pc);
          if (vld && bus.in_ready) begin
            if (pr >= F - 1 && pc >= F - 1)
              sb.push_back('{row: pr - (F - 1), col: pc - (F - 1),
                             z: neuron_all(win_model(v.seed, pr - (F - 1), pc - (F - 1)))});
            if (pr == F - 1 && pc == F - 1) acc_cyc = cyc;
            if (v.glitch && pr == 7 && pc == 2) bus.start = 1'b1;
            if (pc == IMG_W - 1) begin
              pc = 0;
              pr++;
            end else begin
              pc++;
            end
          end
        end else begin
          bus.in_valid = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    check_int("done_seen", int'(got_done), 1);
    check_int("result_count", nres, v.exp_res);
    check_int("scoreboard_empty", sb.size(), 0);
    check_int("pixels_consumed", pr * IMG_W + pc, IMG_W * IMG_H);
`ifdef CONV_SCHED_STATS_EN
    check_int("stall_cnt", int'(stall_cnt), v.exp_stall);
`endif
    @(negedge clk);
    check_int("done_one_cycle", int'(bus.done), 0);
    check_int("idle_after_done", int'(bus.in_ready), 0);
    $display("frame %0d: %0d results in %0d cycles, done=%0d", idx, nres, cyc, got_done);
  endtask

  initial begin
    vec_t tbl[NTBL];
    tbl[0] = '{seed: 0, rand_v: 1'b0, bp_idx: -1, bp_len: 0, glitch: 1'b0, abort_at: -1, exp_res: 100, exp_stall: 0};
    tbl[1] = '{seed: 3, rand_v: 1'b0, bp_idx: 35, bp_len: 7, glitch: 1'b0, abort_at: -1, exp_res: 100, exp_stall: 7};
    tbl[2] = '{seed: 3, rand_v: 1'b1, bp_idx: -1, bp_len: 0, glitch: 1'b0, abort_at: -1, exp_res: 100, exp_stall: 0};
    tbl[3] = '{seed: 1, rand_v: 1'b0, bp_idx: -1, bp_len: 0, glitch: 1'b0, abort_at: 37, exp_res: 37, exp_stall: 0};
    tbl[4] = '{seed: 2, rand_v: 1'b0, bp_idx: -1, bp_len: 0, glitch: 1'b0, abort_at: -1, exp_res: 100, exp_stall: 0};
    tbl[5] = '{seed: 4, rand_v: 1'b1, bp_idx: 60, bp_len: 3, glitch: 1'b1, abort_at: -1, exp_res: 100, exp_stall: 3};

    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.in_pix = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int t = 0; t < NTBL; t++) run_frame(t, tbl[t]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
